// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor controller: FSM encodings and width limit.
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor_cell.sv
// 1-bit full subtractor built from two half subtractors; computes x - y - bin.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_xy (
    .a      (x),
    .b      (y),
    .diff   (d1),
    .borrow (b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs_bin (
    .a      (d1),
    .b      (bin),
    .diff   (d),
    .borrow (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// 1-bit half subtractor primitive: diff = a - b, borrow set when a < b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused for WIDTH cycles, LSB first,
// with a start/busy/done handshake and held diff/borrow_out results.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor_ctrl: WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] sh_r_next;

  full_subtractor_cell u_cell (
    .x    (sh_a_q[0]),
    .y    (sh_b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB; works unchanged for WIDTH == 1.
  assign sh_r_next = WIDTH'({cell_d, sh_r_q} >> 1);

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_r_d   = sh_r_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      S_RUN: begin
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        sh_r_d   = sh_r_next;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          diff_d  = sh_r_next;
          bout_d  = cell_bout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // Idle; the unused encoding also lands here.
        if (start) begin
          sh_a_d   = a;
          sh_b_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_r_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_r_q   <= sh_r_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: expected results and timing queued at start,
// checked every cycle against busy/done/diff/borrow_out.
module tb_serial_subtractor_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  serial_subtractor_ctrl #(
    .WIDTH (WIDTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bo;
    int               acc_e;
    int               done_e;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks;
  int               n_fail;
  int               edge_cnt;
  int               last_done_e;
  int               last_acc;
  bit               mon_en;
  logic [WIDTH-1:0] hold_diff;
  logic             hold_bo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input int acc);
    exp_t e;
    int   full;
    full     = int'(x) - int'(y);
    e.diff   = WIDTH'(full & ((1 << WIDTH) - 1));
    e.bo     = (x < y);
    e.acc_e  = acc;
    e.done_e = acc + WIDTH;
    return e;
  endfunction

  // Every cycle: busy/done must follow the head entry's schedule; results held between dones.
  always @(negedge clk) begin
    if (mon_en) begin
      bit have;
      bit exp_busy;
      bit exp_done;
      have     = (sb_q.size() > 0);
      exp_busy = have && (edge_cnt >= sb_q[0].acc_e) && (edge_cnt < sb_q[0].done_e);
      exp_done = have && (edge_cnt == sb_q[0].done_e);
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        hold_diff = sb_q[0].diff;
        hold_bo   = sb_q[0].bo;
        void'(sb_q.pop_front());
      end
      check_eq("diff", 32'(diff), 32'(hold_diff));
      check_eq("borrow_out", 32'(borrow_out), 32'(hold_bo));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || edge_cnt <= last_done_e) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("idle_timeout", 32'(n), 32'(0));
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    wait_idle();
    start    = 1'b1;
    a        = x;
    b        = y;
    last_acc = edge_cnt + 1;
    e        = make_exp(x, y, last_acc);
    last_done_e = e.done_e;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  initial begin
    exp_t e2;
    int   n;
    n_checks    = 0;
    n_fail      = 0;
    edge_cnt    = 0;
    last_done_e = 0;
    last_acc    = 0;
    mon_en      = 1'b0;
    hold_diff   = '0;
    hold_bo     = 1'b0;

    // Reset held with start asserted: nothing may start.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    do_op(8'd200, 8'd55);
    do_op(8'd5, 8'd9);
    do_op(8'd0, 8'hFF);
    do_op(8'hAA, 8'hAA);

    // Start while busy with changed operands must be ignored.
    do_op(8'd10, 8'd3);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd2;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h33;
    b     = 8'h44;

    // Start held through DONE: next accept is the first edge back in IDLE.
    do_op(8'd50, 8'd20);
    @(negedge clk);
    start = 1'b1;
    a     = 8'd77;
    b     = 8'd7;
    e2    = make_exp(8'd77, 8'd7, last_done_e + 2);
    sb_q.push_back(e2);
    n = 0;
    while (edge_cnt < e2.acc_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    start       = 1'b0;
    last_done_e = e2.done_e;

    // Abort mid-run: no done, results cleared.
    do_op(8'd100, 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    hold_diff   = '0;
    hold_bo     = 1'b0;
    last_done_e = 0;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd3, 8'd1);

    for (int i = 0; i < 5; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom));
    end

    wait_idle();
    check_eq("drain", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
